// File: rtl/bpu_resolve.sv
// EX-stage branch resolution: registered mispredict flags, one-shot redirect and a
// predictor-update FIFO. Define BPU_UPD_MISS_ONLY_EN to enqueue only mispredicted branches.
module bpu_resolve #(
  parameter int FIFO_DEPTH   = 2,
  parameter int FALLTHRU_OFF = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid_i,
  input  logic        is_branch_i,
  input  logic [1:0]  br_type_i,
  input  logic [31:0] pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  input  logic        act_taken_i,
  input  logic [31:0] act_target_i,
  output logic        predict_flag,
  output logic [1:0]  wrong_type,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic [1:0]  upd_type,
  output logic [15:0] drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic [1:0]  btype;
  } upd_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        resolve, mis, push_req, push, pop, full, empty;
  logic        flag_d, flag_q;
  logic [1:0]  wtype_d, wtype_q;
  logic        rvld_d, rvld_q;
  logic [31:0] rpc_d, rpc_q;
  logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [15:0] drop_d, drop_q;
  upd_t        entry;
  upd_t        mem_q [FIFO_DEPTH];

  // Resolution and redirect
  always_comb begin
    resolve = ex_valid_i & is_branch_i & ~stall & ~flush;
    mis     = resolve & ((pred_taken_i != act_taken_i) |
                         (act_taken_i & (pred_target_i != act_target_i)));
    flag_d  = flag_q;
    wtype_d = wtype_q;
    rpc_d   = rpc_q;
    rvld_d  = mis;
    if (!stall) begin
      flag_d  = ~mis;
      wtype_d = mis ? br_type_i : 2'b00;
    end
    if (mis) rpc_d = act_taken_i ? act_target_i : pc_i + 32'(FALLTHRU_OFF);
  end

  // Update FIFO bookkeeping; a full queue still accepts a push when the head leaves
  always_comb begin
`ifdef BPU_UPD_MISS_ONLY_EN
    push_req = mis;
`else
    push_req = resolve;
`endif
    empty    = (cnt_q == '0);
    full     = (cnt_q == DEPTH_C);
    pop      = ~empty & upd_ready;
    push     = push_req & (~full | pop);
    entry    = '{pc: pc_i, target: act_target_i, taken: act_taken_i, btype: br_type_i};
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    drop_d   = (push_req & full & ~pop) ? sat_inc16(drop_q) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q   <= 1'b1;
      wtype_q  <= 2'b00;
      rvld_q   <= 1'b0;
      rpc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      flag_q   <= flag_d;
      wtype_q  <= wtype_d;
      rvld_q   <= rvld_d;
      rpc_q    <= rpc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is data only; validity comes from the occupancy counter
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  assign predict_flag   = flag_q;
  assign wrong_type     = wtype_q;
  assign redirect_valid = rvld_q;
  assign redirect_pc    = rpc_q;
  assign upd_valid      = ~empty;
  assign upd_pc         = mem_q[rd_ptr_q].pc;
  assign upd_target     = mem_q[rd_ptr_q].target;
  assign upd_taken      = mem_q[rd_ptr_q].taken;
  assign upd_type       = mem_q[rd_ptr_q].btype;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_bpu_resolve.sv
// Self-checking bench for bpu_resolve: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_bpu_resolve;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, stall, flush, ex_valid_i, is_branch_i;
  logic [1:0]  br_type_i;
  logic [31:0] pc_i, pred_target_i, act_target_i;
  logic        pred_taken_i, act_taken_i;
  logic        predict_flag, redirect_valid, upd_valid, upd_ready, upd_taken;
  logic [1:0]  wrong_type, upd_type;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [15:0] drop_cnt;

  bpu_resolve #(.FIFO_DEPTH(DEPTH), .FALLTHRU_OFF(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid_i(ex_valid_i), .is_branch_i(is_branch_i), .br_type_i(br_type_i),
    .pc_i(pc_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .act_taken_i(act_taken_i), .act_target_i(act_target_i),
    .predict_flag(predict_flag), .wrong_type(wrong_type),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .upd_type(upd_type),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, target;
    logic        taken;
    logic [1:0]  btype;
  } m_t;

  typedef struct {
    logic        ev, ib, pt, at, st, fl;
    logic [1:0]  t;
    logic [31:0] pc, ptg, atg;
    logic        e_flag, e_rv;
    logic [1:0]  e_wt;
    logic [31:0] e_rpc;
  } vec_t;

  int passed = 0;
  int total  = 0;

  logic        m_flag, m_rv;
  logic [1:0]  m_wt;
  logic [31:0] m_rpc;
  logic [15:0] m_drop;
  m_t          q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic check_model();
    chk("predict_flag", 32'(predict_flag), 32'(m_flag));
    chk("wrong_type", 32'(wrong_type), 32'(m_wt));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    chk("upd_valid", 32'(upd_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("upd_pc", upd_pc, q[0].pc);
      chk("upd_target", upd_target, q[0].target);
      chk("upd_taken", 32'(upd_taken), 32'(q[0].taken));
      chk("upd_type", 32'(upd_type), 32'(q[0].btype));
    end
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // Advance one clock: the model consumes the inputs presented before the edge
  task automatic cycle();
    logic res, ms, pr;
    res = ex_valid_i & is_branch_i & ~stall & ~flush;
    ms  = res & ((pred_taken_i != act_taken_i) |
                 (act_taken_i & (pred_target_i != act_target_i)));
`ifdef BPU_UPD_MISS_ONLY_EN
    pr = ms;
`else
    pr = res;
`endif
    if (reset) begin
      m_flag = 1'b1; m_wt = 2'b00; m_rv = 1'b0; m_rpc = '0; m_drop = '0;
      q.delete();
    end else begin
      if (!stall) begin
        m_flag = ~ms;
        m_wt   = ms ? br_type_i : 2'b00;
      end
      m_rv = ms;
      if (ms) m_rpc = act_taken_i ? act_target_i : pc_i + 32'd8;
      if (q.size() > 0 && upd_ready) void'(q.pop_front());
      if (pr) begin
        if (q.size() < DEPTH) q.push_back('{pc_i, act_target_i, act_taken_i, br_type_i});
        else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic ev, input logic ib, input logic [1:0] t,
                       input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                       input logic at, input logic [31:0] atg);
    ex_valid_i = ev; is_branch_i = ib; br_type_i = t; pc_i = pc;
    pred_taken_i = pt; pred_target_i = ptg; act_taken_i = at; act_target_i = atg;
  endtask

  task automatic idle();
    drive(0, 0, 2'b00, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1; cycle(); reset = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    reset = 1'b1; stall = 0; flush = 0; upd_ready = 1'b1;
    idle();
    cycle(); cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("rst_flag", 32'(predict_flag), 32'd1);
    chk("rst_wtype", 32'(wrong_type), 32'd0);
    chk("rst_updv", 32'(upd_valid), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    //          ev ib pt at st fl  t      pc            ptg          atg        flag rv  wt     rpc
    tbl[0]  = '{1, 1, 0, 1, 0, 0, 2'b11, 32'h1000,     32'h0,       32'h2000, 0, 1, 2'b11, 32'h2000};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,       32'h0,    1, 0, 2'b00, 32'h0};
    tbl[2]  = '{1, 1, 1, 1, 0, 0, 2'b10, 32'h500,      32'h3000,    32'h3010, 0, 1, 2'b10, 32'h3010};
    tbl[3]  = '{1, 1, 1, 0, 0, 0, 2'b11, 32'hFFFFFFFC, 32'h40,      32'h0,    0, 1, 2'b11, 32'h4};
    tbl[4]  = '{1, 1, 1, 1, 0, 0, 2'b01, 32'h600,      32'h700,     32'h700,  1, 0, 2'b00, 32'h0};
    tbl[5]  = '{1, 1, 0, 1, 1, 0, 2'b11, 32'h640,      32'h0,       32'h680,  1, 0, 2'b00, 32'h0};
    tbl[6]  = '{1, 1, 0, 1, 0, 0, 2'b11, 32'h800,      32'h0,       32'h900,  0, 1, 2'b11, 32'h900};
    tbl[7]  = '{1, 1, 1, 1, 1, 1, 2'b01, 32'hA00,      32'hB00,     32'hB04,  0, 0, 2'b11, 32'h0};
    tbl[8]  = '{1, 1, 1, 1, 0, 1, 2'b01, 32'hA00,      32'hB00,     32'hB04,  1, 0, 2'b00, 32'h0};
    tbl[9]  = '{1, 0, 0, 1, 0, 0, 2'b10, 32'hC00,      32'h0,       32'hD00,  1, 0, 2'b00, 32'h0};
    tbl[10] = '{1, 1, 0, 1, 0, 0, 2'b10, 32'h100,      32'h0,       32'h200,  0, 1, 2'b10, 32'h200};
    tbl[11] = '{1, 1, 1, 0, 0, 0, 2'b11, 32'h300,      32'h400,     32'h0,    0, 1, 2'b11, 32'h308};
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ev, tbl[i].ib, tbl[i].t, tbl[i].pc, tbl[i].pt, tbl[i].ptg, tbl[i].at, tbl[i].atg);
      stall = tbl[i].st; flush = tbl[i].fl;
      if (i == 0) upd_ready = 1'b0;
      cycle();
      chk($sformatf("tbl%0d_flag", i), 32'(predict_flag), 32'(tbl[i].e_flag));
      chk($sformatf("tbl%0d_wtype", i), 32'(wrong_type), 32'(tbl[i].e_wt));
      chk($sformatf("tbl%0d_rvld", i), 32'(redirect_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_rpc", i), redirect_pc, tbl[i].e_rpc);
      if (i == 0) begin
        chk("pcr_head_pc", upd_pc, 32'h1000);
        chk("pcr_head_tgt", upd_target, 32'h2000);
        chk("pcr_head_tk", 32'(upd_taken), 32'd1);
        chk("pcr_head_ty", 32'(upd_type), 32'd3);
        upd_ready = 1'b1;
      end
    end
    stall = 0; flush = 0; idle(); cycle();

    // Stall with a mispredicting branch waiting in EX
    drive(1, 1, 2'b01, 32'h2000, 1, 32'h2100, 1, 32'h2100); cycle();
    chk("call_ok_flag", 32'(predict_flag), 32'd1);
    drive(1, 1, 2'b11, 32'h2200, 0, 32'h0, 1, 32'h2400);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_flag", 32'(predict_flag), 32'd1);
      chk("stall_rvld", 32'(redirect_valid), 32'd0);
    end
    stall = 1'b0; cycle();
    chk("unstall_flag", 32'(predict_flag), 32'd0);
    chk("unstall_rpc", redirect_pc, 32'h2400);
    idle(); cycle();
    chk("pulse_once", 32'(redirect_valid), 32'd0);

    // Three pushes into a two-entry FIFO with the consumer blocked
    do_reset();
    upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b11, 32'h4000 + 32'(i * 16), 1, 32'h5000, 1, 32'h5000 + 32'(i)); cycle();
    end
    idle(); cycle();
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    chk("ovf_head", upd_pc, 32'h4000);
    upd_ready = 1'b1; cycle();
    chk("drain_second", upd_pc, 32'h4010);
    cycle();
    chk("drain_empty", 32'(upd_valid), 32'd0);

    // Full, then simultaneous push and pop
    upd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 2'b10, 32'h6000 + 32'(i * 4), 1, 32'h7000, 1, 32'h7000); cycle();
    end
    upd_ready = 1'b1;
    drive(1, 1, 2'b10, 32'h6008, 1, 32'h7000, 1, 32'h7000); cycle();
    chk("pp_drop", 32'(drop_cnt), 32'd1);
    chk("pp_head", upd_pc, 32'h6004);
    idle(); upd_ready = 1'b0; cycle();
    upd_ready = 1'b1; cycle();
    chk("pp_third", upd_pc, 32'h6008);
    cycle();

    // Reset while the queue is draining
    upd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 2'b01, 32'h8000 + 32'(i * 4), 1, 32'h9000, 1, 32'h9000); cycle();
    end
    idle(); upd_ready = 1'b1; cycle();
    do_reset();
    chk("rst_mid_updv", 32'(upd_valid), 32'd0);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] tg;
      tg = $urandom;
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 2'($urandom),
            $urandom, 1'($urandom), ($urandom_range(0, 2) == 0) ? $urandom : tg,
            1'($urandom), tg);
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 6) == 0);
      upd_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 150) == 0);
      cycle();
    end
    reset = 0; stall = 0; flush = 0; idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
